// File: rtl/df_debug_pkg.sv
// Shared definitions for the dataflow debug aggregators (watchdog FSM states, report record, widths).
// Latency: n/a (types, constants and one pure width function only).
// Backpressure: n/a.
package df_debug_pkg;

  // Watchdog report FSM: SCAN looks for an eligible monitor, REPORT holds one report on the channel.
  typedef enum logic {
    SCAN   = 1'b0,
    REPORT = 1'b1
  } wd_state_e;

  localparam int DEF_PERSIST = 16;

  // Widest index and snapshot a report record can carry (NUM_MON <= 16, SNAP_W <= 64).
  localparam int MAX_IDX_W  = 4;
  localparam int MAX_SNAP_W = 64;

  // One deadlock report: monitor index, cycle stamp at grant, captured snapshot.
  typedef struct packed {
    logic [MAX_IDX_W-1:0]  idx;
    logic [31:0]           ts;
    logic [MAX_SNAP_W-1:0] snap;
  } rpt_t;

  // Index width for n requesters, never below 1 bit.
  function automatic int IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/df_deadlock_watchdog_if.sv
// Report channel between the deadlock watchdog and its consumer (testbench or debug interrupt logic).
// Latency: n/a (signal bundle only).
// Backpressure: rpt_valid/rpt_ready; the master holds idx/time/snap stable while valid && !ready.
// Ports: master drives rpt_valid, rpt_idx, rpt_time, rpt_snap and receives rpt_ready; slave is the mirror.
interface df_deadlock_watchdog_if #(
  parameter int NUM_MON = 4,
  parameter int SNAP_W  = 20
);
  localparam int IW = df_debug_pkg::IDX_W(NUM_MON);

  logic              rpt_valid;
  logic              rpt_ready;
  logic [IW-1:0]     rpt_idx;
  logic [31:0]       rpt_time;
  logic [SNAP_W-1:0] rpt_snap;

  modport master (output rpt_valid, rpt_idx, rpt_time, rpt_snap, input rpt_ready);
  modport slave  (input rpt_valid, rpt_idx, rpt_time, rpt_snap, output rpt_ready);

endinterface

// File: rtl/df_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr_i, wrapping at N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is taken and advances ptr_i.
// Ports: req_i requests, ptr_i priority start, gnt_vld_o any grant, gnt_oh_o one-hot grant, gnt_idx_o its index.
module df_rr_arbiter
  import df_debug_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = IDX_W(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          gnt_vld_o,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!gnt_vld_o && req_i[cand]) begin
        gnt_vld_o      = 1'b1;
        gnt_idx_o      = cand;
        gnt_oh_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/df_deadlock_watchdog.sv
// Reports each monitor whose block flag persists PERSIST cycles, once per episode, over one rr-arbitrated channel.
// Latency: grant at edge E0+PERSIST when block is first sampled high at E0 (FSM idle, no competitor).
// Backpressure: report held stable until rpt_valid && rpt_ready; >=1 idle cycle between reports; clear drops it.
// Ports: clk/rst (async active-high), enable_i, clear_i, mon_block_i, mon_snap_i, rpt (master), any_deadlock_o.
// Build option DF_DEADLOCK_SNAPSHOT_EN: latch the granted monitor's mon_snap slice into rpt_snap (else tied 0).
module df_deadlock_watchdog
  import df_debug_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int PERSIST = DEF_PERSIST,
  parameter int SNAP_W  = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic [NUM_MON-1:0]        mon_block_i,
  input  logic [NUM_MON*SNAP_W-1:0] mon_snap_i,
  df_deadlock_watchdog_if.master    rpt,
  output logic                      any_deadlock_o
);

  localparam int               IW       = IDX_W(NUM_MON);
  localparam int               CNT_W    = $clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERSIST);
  localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_MON - 1);

  wd_state_e          state_q, state_d;
  logic [31:0]        cyc_q;
  logic [CNT_W-1:0]   cnt_q [NUM_MON];
  logic [NUM_MON-1:0] reported_q, reported_d, eligible;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d, idx_q;
  logic [31:0]        time_q;
  logic               gnt_vld, grant;
  logic [NUM_MON-1:0] gnt_oh;
  logic [IW-1:0]      gnt_idx;

  // Persistence counters: any gap (block low, enable low, clear) restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_MON; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MON; i++) begin
        if (clear_i || !enable_i || !mon_block_i[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] != CNT_MAX)                cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_MON; i++) eligible[i] = (cnt_q[i] == CNT_MAX) && !reported_q[i];
  end

  df_rr_arbiter #(.N(NUM_MON)) u_arb (
    .req_i     (eligible),
    .ptr_i     (rr_ptr_q),
    .gnt_vld_o (gnt_vld),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  // clear overrides both a grant and a handshake; rr_ptr only moves on a completed handshake.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (clear_i) begin
      state_d = SCAN;
    end else begin
      case (state_q)
        SCAN: if (gnt_vld) begin
          state_d = REPORT;
          grant   = 1'b1;
        end
        REPORT: if (rpt.rpt_ready) begin
          state_d  = SCAN;
          rr_ptr_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // A low block sample ends the episode even on the grant edge itself, so a re-rising
  // block always starts a fresh, reportable episode.
  assign reported_d = clear_i ? '0 : ((reported_q | (grant ? gnt_oh : '0)) & mon_block_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      cyc_q      <= '0;
      reported_q <= '0;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      time_q     <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_q + 32'd1;
      reported_q <= reported_d;
      rr_ptr_q   <= rr_ptr_d;
      if (grant) begin
        idx_q  <= gnt_idx;
        time_q <= cyc_q;
      end
    end
  end

`ifdef DF_DEADLOCK_SNAPSHOT_EN
  logic [SNAP_W-1:0] snap_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        snap_q <= '0;
    else if (grant) snap_q <= mon_snap_i[gnt_idx*SNAP_W +: SNAP_W];
  end
  assign rpt.rpt_snap = snap_q;
`else
  logic unused_snap;
  assign unused_snap  = ^mon_snap_i;
  assign rpt.rpt_snap = '0;
`endif

  assign rpt.rpt_valid   = (state_q == REPORT);
  assign rpt.rpt_idx     = idx_q;
  assign rpt.rpt_time    = time_q;
  assign any_deadlock_o  = |reported_q;

endmodule

// File: tb/tb_df_deadlock_watchdog.sv
module tb_df_deadlock_watchdog;
  import df_debug_pkg::*;

  localparam int N  = 4;
  localparam int P  = 16;
  localparam int SW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [N-1:0]  mon_block = '0;
  logic [N*SW-1:0] mon_snap = '0;
  logic          any_deadlock;

  df_deadlock_watchdog_if #(.NUM_MON(N), .SNAP_W(SW)) rpt ();

  df_deadlock_watchdog #(.NUM_MON(N), .PERSIST(P), .SNAP_W(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable),
    .clear_i        (clear),
    .mon_block_i    (mon_block),
    .mon_snap_i     (mon_snap),
    .rpt            (rpt.master),
    .any_deadlock_o (any_deadlock)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-monitor run length of enabled block samples, one-shot flag per
  // episode, a single outstanding report, and a rotating priority start.
  int          run [N];
  bit          rep [N];
  bit          m_busy = 1'b0;
  int          m_ptr = 0;
  int          m_idx = 0;
  int          mj;
  logic [31:0] m_cyc = '0;
  rpt_t        exp_q[$];
  rpt_t        e_new;

  initial for (int i = 0; i < N; i++) begin run[i] = 0; rep[i] = 1'b0; end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin run[i] = 0; rep[i] = 1'b0; end
      m_busy = 1'b0; m_ptr = 0; m_idx = 0; m_cyc = '0;
      exp_q.delete();
    end else begin
      if (clear) begin
        if (m_busy) void'(exp_q.pop_back());
        m_busy = 1'b0;
        for (int i = 0; i < N; i++) begin run[i] = 0; rep[i] = 1'b0; end
      end else begin
        if (m_busy) begin
          if (rpt.rpt_ready) begin
            m_busy = 1'b0;
            m_ptr  = (m_idx + 1) % N;
          end
        end else begin
          for (int k = 0; k < N; k++) begin
            mj = (m_ptr + k) % N;
            if (!m_busy && run[mj] >= P && !rep[mj]) begin
              m_busy = 1'b1;
              m_idx  = mj;
              rep[mj] = 1'b1;
              e_new.idx  = 4'(mj);
              e_new.ts   = m_cyc;
              e_new.snap = '0;
`ifdef DF_DEADLOCK_SNAPSHOT_EN
              e_new.snap = 64'(mon_snap[mj*SW +: SW]);
`endif
              exp_q.push_back(e_new);
            end
          end
        end
        for (int i = 0; i < N; i++) begin
          run[i] = (enable && mon_block[i]) ? ((run[i] < P) ? run[i] + 1 : P) : 0;
          if (!mon_block[i]) rep[i] = 1'b0;
        end
      end
      m_cyc = m_cyc + 32'd1;
    end
  end

  // Monitor: checks channel state every cycle and scores each accepted report.
  bit   m_any;
  rpt_t e_got;
  always @(negedge clk) begin
    if (!rst) begin
      m_any = 1'b0;
      for (int i = 0; i < N; i++) m_any = m_any | rep[i];
      chk("rpt_valid", 64'(rpt.rpt_valid), 64'(m_busy));
      chk("any_deadlock", 64'(any_deadlock), 64'(m_any));
      if (rpt.rpt_valid && rpt.rpt_ready && !clear) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_report actual=idx%0d required=none at %0t", rpt.rpt_idx, $time);
        end else begin
          e_got = exp_q.pop_front();
          chk("rpt_idx", 64'(rpt.rpt_idx), 64'(e_got.idx));
          chk("rpt_time", 64'(rpt.rpt_time), 64'(e_got.ts));
          chk("rpt_snap", 64'(rpt.rpt_snap), e_got.snap);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int waited;
    waited = 0;
    while (!rpt.rpt_valid && waited < 300) begin tick(1); waited++; end
    chk(name, 64'(rpt.rpt_valid), 64'd1);
  endtask

  bit saw_valid;

  initial begin
    rpt.rpt_ready = 1'b0;
    tick(2);
    chk("reset_valid", 64'(rpt.rpt_valid), 64'd0);
    chk("reset_idx", 64'(rpt.rpt_idx), 64'd0);
    chk("reset_time", 64'(rpt.rpt_time), 64'd0);
    chk("reset_snap", 64'(rpt.rpt_snap), 64'd0);
    chk("reset_any", 64'(any_deadlock), 64'd0);
    rst = 1'b0;
    enable = 1'b1;

    // Latency: block[2] first sampled at edge 10, report at edge 26 stamped 26.
    tick(10);
    mon_block[2] = 1'b1;
    tick(16);
    chk("lat_not_yet", 64'(rpt.rpt_valid), 64'd0);
    tick(1);
    chk("lat_valid", 64'(rpt.rpt_valid), 64'd1);
    chk("lat_idx", 64'(rpt.rpt_idx), 64'd2);
    chk("lat_time", 64'(rpt.rpt_time), 64'd26);
    chk("lat_any", 64'(any_deadlock), 64'd1);

    // Stall: outputs hold while other inputs churn.
    repeat (20) begin
      mon_snap = (N*SW)'({$urandom, $urandom, $urandom});
      mon_block[1:0] = 2'($urandom);
      tick(1);
      chk("hold_idx", 64'(rpt.rpt_idx), 64'd2);
      chk("hold_time", 64'(rpt.rpt_time), 64'd26);
    end
    mon_block[1:0] = 2'b00;
    rpt.rpt_ready = 1'b1;

    // Same episode stays reported; a one-cycle drop re-arms it.
    tick(100);
    chk("no_rereport", 64'(rpt.rpt_valid), 64'd0);
    mon_block[2] = 1'b0;
    tick(1);
    mon_block[2] = 1'b1;
    tick(16);
    chk("rearm_not_yet", 64'(rpt.rpt_valid), 64'd0);
    tick(1);
    chk("rearm_valid", 64'(rpt.rpt_valid), 64'd1);
    chk("rearm_idx", 64'(rpt.rpt_idx), 64'd2);

    // clear together with ready: report dropped, flags gone.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear_valid", 64'(rpt.rpt_valid), 64'd0);
    chk("clear_any", 64'(any_deadlock), 64'd0);
    mon_block = '0;
    tick(2);

    // 15 high, 1 low, 15 high never reaches persistence.
    saw_valid = 1'b0;
    for (int c = 0; c < 31; c++) begin
      mon_block[1] = (c != 15);
      tick(1);
      saw_valid = saw_valid | rpt.rpt_valid;
    end
    chk("short_runs", 64'(saw_valid), 64'd0);
    mon_block = '0;
    tick(1);

    // Three monitors eligible on the same edge.
    mon_block = 4'b1011;
    tick(40);
    mon_block = '0;
    tick(2);

    // Randomized traffic: long block runs, occasional clear/enable gaps, random ready.
    repeat (4000) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 39) == 0) mon_block[i] = ~mon_block[i];
      enable = ($urandom_range(0, 299) != 0);
      clear  = ($urandom_range(0, 249) == 0);
      rpt.rpt_ready = ($urandom_range(0, 3) != 0);
      mon_snap = (N*SW)'({$urandom, $urandom, $urandom});
      tick(1);
    end
    clear = 1'b0;
    enable = 1'b1;

    // Asynchronous reset in the middle of a pending report.
    rpt.rpt_ready = 1'b0;
    mon_block = 4'b1000;
    wait_valid("wait_valid_pre_reset");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(rpt.rpt_valid), 64'd0);
    chk("arst_idx", 64'(rpt.rpt_idx), 64'd0);
    chk("arst_time", 64'(rpt.rpt_time), 64'd0);
    chk("arst_snap", 64'(rpt.rpt_snap), 64'd0);
    chk("arst_any", 64'(any_deadlock), 64'd0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
